// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, flag bit positions,
// issue FSM encoding and the PSR write-enable rule.
package alu_issue_ctrl_pkg;

    localparam logic [7:0] OP_AND = 8'h01;
    localparam logic [7:0] OP_XOR = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h05;
    localparam logic [7:0] OP_SUB = 8'h09;
    localparam logic [7:0] OP_CMP = 8'h0B;
    localparam logic [7:0] OP_MOV = 8'h0D;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;
    localparam int FLAG_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    // mov is the only opcode that leaves the architectural flags untouched
    function automatic logic op_writes_psr(input logic [7:0] op);
        return (op != OP_MOV);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_alu.sv
// Shared 16-bit ALU: combinational result and {C,L,F,Z,N} flags.
// Undefined opcodes shift A left by ImmLo.
module alu
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              Cin,
    input  logic [7:0]        aluop,
    input  logic [3:0]        ImmLo,
    output logic [FLAG_W-1:0] Flags,
    output logic [WIDTH-1:0]  Result
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_dif;
    logic           w_c;
    logic           w_l;
    logic           w_f;
    logic           w_n;

    // Result and flag evaluation for the current opcode
    always_comb begin
        w_sum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
        w_dif  = {1'b0, A} - {1'b0, B};
        Result = {WIDTH{1'b0}};
        w_c    = 1'b0;
        w_l    = 1'b0;
        w_f    = 1'b0;
        case (aluop)
            OP_AND: Result = A & B;
            OP_XOR: Result = A ^ B;
            OP_ADD: begin
                Result = w_sum[WIDTH-1:0];
                w_c    = w_sum[WIDTH];
                w_f    = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                Result = w_dif[WIDTH-1:0];
                w_c    = w_dif[WIDTH];
                w_l    = w_dif[WIDTH];
                w_f    = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MOV:  Result = B;
            default: Result = A << ImmLo;
        endcase
        // cmp reports signed less-than on N, everything else the result sign
        w_n = (aluop == OP_CMP) ? (w_dif[WIDTH-1] ^ w_f) : Result[WIDTH-1];
        Flags         = {FLAG_W{1'b0}};
        Flags[FLAG_C] = w_c;
        Flags[FLAG_L] = w_l;
        Flags[FLAG_F] = w_f;
        Flags[FLAG_Z] = (Result == {WIDTH{1'b0}});
        Flags[FLAG_N] = w_n;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-requester issue controller for the shared ALU with response handshake and PSR.
// Define ALU_ISSUE_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [WIDTH-1:0]  r0_a,
    input  logic [WIDTH-1:0]  r0_b,
    input  logic [7:0]        r0_op,
    input  logic [3:0]        r0_imm,
    input  logic              r0_cin,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [WIDTH-1:0]  r1_a,
    input  logic [WIDTH-1:0]  r1_b,
    input  logic [7:0]        r1_op,
    input  logic [3:0]        r1_imm,
    input  logic              r1_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [WIDTH-1:0]  rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [FLAG_W-1:0] psr_flags
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               w_grant_id;
    logic               w_r0_ready;
    logic               w_r1_ready;
    logic               w_accept;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [7:0]         r_op;
    logic [3:0]         r_imm;
    logic               r_cin;
    logic               r_id;

    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_result;
    logic [FLAG_W-1:0]  r_rsp_flags;
    logic [FLAG_W-1:0]  r_psr;

    logic [FLAG_W-1:0]  w_alu_flags;
    logic [WIDTH-1:0]   w_alu_result;

`ifdef ALU_ISSUE_RR_EN
    logic               r_last_grant;

    // Tie goes to the requester that did not win the previous accept
    always_comb begin
        if (r0_valid && r1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = r1_valid && !r0_valid;
        end
    end

    // Remember the most recent winner; reset favours requester 0 on the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end
`else
    // Fixed priority: requester 1 wins only when requester 0 is idle
    always_comb begin
        w_grant_id = r1_valid && !r0_valid;
    end
`endif

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue FSM next state and request handshake
    always_comb begin
        w_state_nxt = r_state;
        w_r0_ready  = 1'b0;
        w_r1_ready  = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                w_r0_ready = r0_valid && !w_grant_id;
                w_r1_ready = r1_valid && w_grant_id;
                w_accept   = w_r0_ready || w_r1_ready;
                if (w_accept) begin
                    w_state_nxt = EXEC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            EXEC: w_state_nxt = DONE;
            DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture from the granted requester
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= {WIDTH{1'b0}};
            r_b   <= {WIDTH{1'b0}};
            r_op  <= 8'h00;
            r_imm <= 4'h0;
            r_cin <= 1'b0;
            r_id  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= w_grant_id ? r1_a   : r0_a;
            r_b   <= w_grant_id ? r1_b   : r0_b;
            r_op  <= w_grant_id ? r1_op  : r0_op;
            r_imm <= w_grant_id ? r1_imm : r0_imm;
            r_cin <= w_grant_id ? r1_cin : r0_cin;
            r_id  <= w_grant_id;
        end else begin
            r_a   <= r_a;
            r_b   <= r_b;
            r_op  <= r_op;
            r_imm <= r_imm;
            r_cin <= r_cin;
            r_id  <= r_id;
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .A      (r_a),
        .B      (r_b),
        .Cin    (r_cin),
        .aluop  (r_op),
        .ImmLo  (r_imm),
        .Flags  (w_alu_flags),
        .Result (w_alu_result)
    );

    // Response and PSR capture at the end of EXEC; held while DONE waits for the consumer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_id     <= 1'b0;
            r_rsp_result <= {WIDTH{1'b0}};
            r_rsp_flags  <= {FLAG_W{1'b0}};
            r_psr        <= {FLAG_W{1'b0}};
        end else if (r_state == EXEC) begin
            r_rsp_id     <= r_id;
            r_rsp_result <= w_alu_result;
            r_rsp_flags  <= w_alu_flags;
            r_psr        <= op_writes_psr(r_op) ? w_alu_flags : r_psr;
        end else begin
            r_rsp_id     <= r_rsp_id;
            r_rsp_result <= r_rsp_result;
            r_rsp_flags  <= r_rsp_flags;
            r_psr        <= r_psr;
        end
    end

    assign r0_ready   = w_r0_ready;
    assign r1_ready   = w_r1_ready;
    assign rsp_valid  = (r_state == DONE);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign psr_flags  = r_psr;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized single
// requests, checked against a transaction-level arithmetic model of the ALU and PSR.
module tb_alu_issue_ctrl;

    localparam logic [7:0] T_AND = 8'h01;
    localparam logic [7:0] T_XOR = 8'h03;
    localparam logic [7:0] T_ADD = 8'h05;
    localparam logic [7:0] T_SUB = 8'h09;
    localparam logic [7:0] T_CMP = 8'h0B;
    localparam logic [7:0] T_MOV = 8'h0D;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r0_ready, r0_cin, r1_valid, r1_ready, r1_cin;
    logic [15:0] r0_a, r0_b, r1_a, r1_b;
    logic [7:0]  r0_op, r1_op;
    logic [3:0]  r0_imm, r1_imm;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_result;
    logic [4:0]  rsp_flags, psr_flags;

    int          checks   = 0;
    int          failures = 0;
    logic [4:0]  m_psr;
    bit          m_last;
    logic [15:0] e_res;
    logic [4:0]  e_fl;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_op(r0_op), .r0_imm(r0_imm), .r0_cin(r0_cin),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_op(r1_op), .r1_imm(r1_imm), .r1_cin(r1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .psr_flags(psr_flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: flags from plain integer arithmetic, bit order {C,L,F,Z,N}
    function automatic void model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] imm, input logic cin,
                                  output logic [15:0] res, output logic [4:0] fl);
        int sa, sb, sr, us;
        bit c, l, f, n;
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0; l = 1'b0; f = 1'b0;
        case (op)
            T_AND: res = a & b;
            T_XOR: res = a ^ b;
            T_ADD: begin
                us  = int'(a) + int'(b) + int'(cin);
                res = us[15:0];
                c   = (us > 65535);
                sr  = sa + sb + int'(cin);
                f   = (sr > 32767) || (sr < -32768);
            end
            T_SUB, T_CMP: begin
                res = a - b;
                c   = (a < b);
                l   = (a < b);
                sr  = sa - sb;
                f   = (sr > 32767) || (sr < -32768);
            end
            T_MOV:   res = b;
            default: res = 16'(a << imm);
        endcase
        n  = (op == T_CMP) ? (sa < sb) : res[15];
        fl = {c, l, f, (res == 16'h0000), n};
    endfunction

    task automatic set_req(input bit id, input logic [7:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] imm, input logic cin);
        if (id) begin
            r1_op = op; r1_a = a; r1_b = b; r1_imm = imm; r1_cin = cin;
        end else begin
            r0_op = op; r0_a = a; r0_b = b; r0_imm = imm; r0_cin = cin;
        end
    endtask

    task automatic check_rsp(input string tag, input bit id);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'(e_res));
        check({tag, "_rsp_flags"}, 32'(rsp_flags), 32'(e_fl));
        check({tag, "_psr"}, 32'(psr_flags), 32'(m_psr));
    endtask

    // One request from a single requester; entered and left at posedge+1 in IDLE with rsp_ready=1
    task automatic issue(input string tag, input bit id, input logic [7:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] imm, input logic cin);
        set_req(id, op, a, b, imm, cin);
        r0_valid = !id;
        r1_valid = id;
        #1;
        check({tag, "_ready"}, {30'd0, r1_ready, r0_ready}, id ? 32'd2 : 32'd1);
        @(posedge clk); #1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        m_last = id;
        model(op, a, b, imm, cin, e_res, e_fl);
        if (op != T_MOV) m_psr = e_fl;
        check({tag, "_exec_no_rsp"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check_rsp(tag, id);
        @(posedge clk); #1;
        check({tag, "_back_idle"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_psr = 5'd0;
        m_last = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        check({tag, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
        check({tag, "_psr"}, 32'(psr_flags), 32'd0);
    endtask

    initial begin
        logic [7:0] ops [6];
        logic [7:0] rop;
        bit         exp_g;
        bit         rid;
        ops[0] = T_AND; ops[1] = T_XOR; ops[2] = T_ADD;
        ops[3] = T_SUB; ops[4] = T_CMP; ops[5] = T_MOV;
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
        set_req(1'b0, 8'h00, 16'h0, 16'h0, 4'h0, 1'b0);
        set_req(1'b1, 8'h00, 16'h0, 16'h0, 4'h0, 1'b0);

        // Reset state
        do_reset();
        check_reset_state("reset");
        check("reset_ready", {30'd0, r1_ready, r0_ready}, 32'd0);

        // Directed arithmetic
        issue("add", 1'b0, T_ADD, 16'd8, 16'd9, 4'h0, 1'b0);
        check("add_result_17", 32'(rsp_result), 32'd17);
        issue("sub", 1'b1, T_SUB, 16'd321, 16'd300, 4'h0, 1'b0);
        check("sub_result_21", 32'(rsp_result), 32'd21);
        issue("cmp", 1'b0, T_CMP, 16'd90, 16'd90, 4'h0, 1'b0);
        check("cmp_psr_z", 32'(psr_flags[1]), 32'd1);
        issue("mov", 1'b0, T_MOV, 16'd0, 16'd20, 4'h0, 1'b0);
        check("mov_result_20", 32'(rsp_result), 32'd20);
        check("mov_psr_z_kept", 32'(psr_flags[1]), 32'd1);

        // Both requesters continuously valid with xor 5,0
        do_reset();
        set_req(1'b0, T_XOR, 16'd5, 16'd0, 4'h0, 1'b0);
        set_req(1'b1, T_XOR, 16'd5, 16'd0, 4'h0, 1'b0);
        r0_valid = 1'b1; r1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ISSUE_RR_EN
            exp_g = !m_last;
`else
            exp_g = 1'b0;
`endif
            #1;
            check("tie_grant", {30'd0, r1_ready, r0_ready}, exp_g ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            m_last = exp_g;
            model(T_XOR, 16'd5, 16'd0, 4'h0, 1'b0, e_res, e_fl);
            m_psr = e_fl;
            check("tie_exec_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
            @(posedge clk); #1;
            check_rsp("tie", exp_g);
            check("tie_result_5", 32'(rsp_result), 32'd5);
            @(posedge clk);
        end
        #1;
        r0_valid = 1'b0; r1_valid = 1'b0;

        // Consumer stalls 4 cycles in DONE while r1 waits
        set_req(1'b0, T_ADD, 16'hFFFF, 16'h0002, 4'h0, 1'b1);
        r0_valid = 1'b1;
        rsp_ready = 1'b0;
        #1;
        check("stall_accept", 32'(r0_ready), 32'd1);
        @(posedge clk); #1;
        r0_valid = 1'b0;
        m_last = 1'b0;
        model(T_ADD, 16'hFFFF, 16'h0002, 4'h0, 1'b1, e_res, e_fl);
        m_psr = e_fl;
        set_req(1'b1, T_SUB, 16'd100, 16'd7, 4'h0, 1'b0);
        r1_valid = 1'b1;
        #1;
        check("stall_exec_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            check_rsp("stall", 1'b0);
            check("stall_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_idle", 32'(rsp_valid), 32'd0);
        check("stall_pending_r1", {30'd0, r1_ready, r0_ready}, 32'd2);
        @(posedge clk); #1;
        r1_valid = 1'b0;
        m_last = 1'b1;
        model(T_SUB, 16'd100, 16'd7, 4'h0, 1'b0, e_res, e_fl);
        m_psr = e_fl;
        @(posedge clk); #1;
        check_rsp("pending", 1'b1);
        @(posedge clk); #1;

        // Reset during EXEC aborts the operation
        set_req(1'b0, T_AND, 16'd3, 16'd1, 4'h0, 1'b0);
        r0_valid = 1'b1;
        #1;
        check("abort_accept", 32'(r0_ready), 32'd1);
        @(posedge clk); #1;
        r0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_psr = 5'd0;
        m_last = 1'b1;
        check_reset_state("abort");
        issue("post_abort", 1'b0, T_ADD, 16'd1, 16'd2, 4'h0, 1'b0);

        // Randomized single requests, including undefined opcodes
        for (int k = 0; k < 40; k++) begin
            rop = ($urandom_range(0, 7) > 5) ? 8'($urandom) : ops[$urandom_range(0, 5)];
            rid = 1'($urandom);
            issue("rand", rid, rop, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
